// File: rtl/dot_board_scan.sv
// dot_board_scan: row-scanning driver for the 10x14 dot-matrix game panel with per-frame snapshot and win blink
module dot_board_scan #(
  parameter int ROW_DIV    = 5000,
  parameter int BLANK_CYC  = 4,
  parameter int BLINK_FRMS = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [17:0] board,
  input  logic        is_right,
  input  logic        turn_o,
  input  logic [8:0]  win_mask,
  output logic [9:0]  dot_row,
  output logic [13:0] dot_col,
  output logic        frame_start
);
  localparam int DW = $clog2(ROW_DIV);
  localparam int BW = $clog2(BLINK_FRMS + 1);
  typedef enum logic {BLANK, DRIVE} state_t;
  state_t st, nxt;
  logic [DW-1:0] div_cnt;
  logic [3:0] row_idx;
  logic [BW-1:0] blink_cnt;
  logic blink_on, load, snap_right, snap_turn;
  logic [17:0] snap_board;
  logic [8:0] snap_win, v;
  logic [9:0] row_q;
  logic [13:0] col_q, pix;
  logic [3:0] q;
  logic [1:0] m;
  logic [2:0] cg [9];

  function automatic logic [2:0] glyph(input logic o, input logic x, input logic hide, input logic [1:0] gr);
    return (hide || !(o || x)) ? 3'b000 : (o && x) ? 3'b111 :
           x ? (gr == 2'd1 ? 3'b010 : 3'b101) : (gr == 2'd1 ? 3'b101 : 3'b111);
  endfunction

  assign load = en && div_cnt == '0 && row_idx == '0;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      row_idx <= '0;
    end else if (div_cnt == DW'(ROW_DIV - 1)) begin
      div_cnt <= '0;
      row_idx <= row_idx == 4'd9 ? 4'd0 : row_idx + 4'd1;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_board <= '0;
      snap_right <= 1'b0;
      snap_turn  <= 1'b0;
      snap_win   <= '0;
      blink_cnt  <= '0;
      blink_on   <= 1'b1;
    end else if (load) begin
      snap_board <= board;
      snap_right <= is_right;
      snap_turn  <= turn_o;
      snap_win   <= win_mask;
      blink_cnt  <= blink_cnt == BW'(BLINK_FRMS - 1) ? '0 : blink_cnt + BW'(1);
      if (blink_cnt == BW'(BLINK_FRMS - 1)) blink_on <= ~blink_on;
    end else if (!en) begin
      blink_cnt <= '0;
    end
  end

  assign q = row_idx / 4'd3;
  assign m = 2'(row_idx - q * 4'd3);

  for (genvar k = 0; k < 9; k++) begin : g_cell
    logic [2:0] g;
    assign g = glyph(snap_board[17-2*k], snap_board[16-2*k], snap_win[k] & ~blink_on, m);
    assign cg[k] = {g[0], g[1], g[2]};
  end

  always_comb begin
    v = q == 4'd0 ? {cg[2], cg[1], cg[0]} :
        q == 4'd1 ? {cg[5], cg[4], cg[3]} :
        q == 4'd2 ? {cg[8], cg[7], cg[6]} :
        (snap_turn ? 9'h1c0 : 9'h007);
    pix = snap_right ? {v, 5'b0} : {5'b0, v};
    nxt = (en && div_cnt >= DW'(BLANK_CYC)) ? DRIVE : BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= BLANK;
      row_q       <= '0;
      col_q       <= '0;
      frame_start <= 1'b0;
    end else begin
      st          <= nxt;
      row_q       <= 10'b1 << row_idx;
      col_q       <= pix;
      frame_start <= load;
    end
  end

  assign dot_row = st == DRIVE ? row_q : '0;
  assign dot_col = st == DRIVE ? col_q : '0;
endmodule

// File: tb/tb_dot_board_scan.sv
// tb_dot_board_scan: directed self-checking bench for dot_board_scan
module tb_dot_board_scan;
  localparam int RD = 20;
  logic clk = 0, rst = 1, en = 1, is_right = 0, turn_o = 0;
  logic [17:0] board = '0;
  logic [8:0] win_mask = '0;
  logic [9:0] dot_row;
  logic [13:0] dot_col;
  logic frame_start;
  int checks = 0, errors = 0;
  logic [9:0] cr [10];
  logic [13:0] cc [10];
  logic [23:0] bl [10];

  dot_board_scan #(.ROW_DIV(RD), .BLANK_CYC(4), .BLINK_FRMS(2)) dut (
    .clk(clk), .rst(rst), .en(en), .board(board), .is_right(is_right), .turn_o(turn_o),
    .win_mask(win_mask), .dot_row(dot_row), .dot_col(dot_col), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs;
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < 1000) begin
      tick;
      n++;
    end
    if (frame_start !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_fs: frame_start=%b after %0d cycles, want 1", frame_start, n);
    end
  endtask

  task automatic cap_frame(input int chg_r, input logic [17:0] nb, input logic nt);
    int jj;
    jj = 1;
    for (int r = 0; r < 10; r++) begin
      while (jj < r * RD + 2) begin tick; jj++; end
      bl[r] = {dot_row, dot_col};
      while (jj < r * RD + 11) begin tick; jj++; end
      cr[r] = dot_row;
      cc[r] = dot_col;
      if (r == chg_r) begin
        board = nb;
        turn_o = nt;
      end
    end
  endtask

  task automatic test_reset;
    logic [13:0] e [10];
    e = '{14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h007};
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (dot_row !== 10'h0 || dot_col !== 14'h0 || frame_start !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: row=%b col=%h fs=%b, want all 0", dot_row, dot_col, frame_start);
      end
    end
    rst = 0;
    tick;
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_fs: fs=%b, want 1", frame_start);
    end
    cap_frame(-1, '0, 1'b0);
    for (int r = 0; r < 10; r++) begin
      checks++;
      if (cr[r] !== (10'b1 << r) || cc[r] !== e[r] || bl[r] !== 24'h0) begin
        errors++;
        $display("FAIL reset_frame row %0d: row=%b col=%h blank=%h, want row=%b col=%h blank=0", r, cr[r], cc[r], bl[r], 10'b1 << r, e[r]);
      end
    end
  endtask

  task automatic test_period;
    int n;
    wait_fs;
    n = 0;
    do begin
      tick;
      n++;
    end while (frame_start !== 1'b1 && n < 1000);
    checks++;
    if (n !== 10 * RD) begin
      errors++;
      $display("FAIL frame_period: %0d cycles, want %0d", n, 10 * RD);
    end
  endtask

  task automatic test_x_cell1;
    logic [13:0] e [10];
    e = '{14'h005, 14'h002, 14'h005, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h007};
    tick;
    board = 18'h10000;
    is_right = 0;
    turn_o = 0;
    wait_fs;
    cap_frame(-1, '0, 1'b0);
    for (int r = 0; r < 10; r++) begin
      checks++;
      if (cr[r] !== (10'b1 << r) || cc[r] !== e[r] || bl[r] !== 24'h0) begin
        errors++;
        $display("FAIL x_cell1 row %0d: row=%b col=%h blank=%h, want row=%b col=%h blank=0", r, cr[r], cc[r], bl[r], 10'b1 << r, e[r]);
      end
    end
  endtask

  task automatic test_o_cell9;
    logic [13:0] e [10];
    e = '{14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h3800, 14'h2800, 14'h3800, 14'h3800};
    board = 18'h00002;
    is_right = 1;
    turn_o = 1;
    wait_fs;
    cap_frame(-1, '0, 1'b1);
    for (int r = 0; r < 10; r++) begin
      checks++;
      if (cr[r] !== (10'b1 << r) || cc[r] !== e[r]) begin
        errors++;
        $display("FAIL o_cell9 row %0d: row=%b col=%h, want row=%b col=%h", r, cr[r], cc[r], 10'b1 << r, e[r]);
      end
    end
  endtask

  task automatic test_tear_free;
    logic [13:0] eo [10];
    logic [13:0] en_ [10];
    eo  = '{14'h005, 14'h002, 14'h005, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h007};
    en_ = '{14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h0, 14'h1c0, 14'h140, 14'h1c0, 14'h1c0};
    board = 18'h10000;
    is_right = 0;
    turn_o = 0;
    wait_fs;
    cap_frame(4, 18'h00002, 1'b1);
    for (int r = 0; r < 10; r++) begin
      checks++;
      if (cc[r] !== eo[r]) begin
        errors++;
        $display("FAIL tear_old row %0d: col=%h, want %h", r, cc[r], eo[r]);
      end
    end
    wait_fs;
    cap_frame(-1, '0, 1'b1);
    for (int r = 0; r < 10; r++) begin
      checks++;
      if (cc[r] !== en_[r]) begin
        errors++;
        $display("FAIL tear_new row %0d: col=%h, want %h", r, cc[r], en_[r]);
      end
    end
  endtask

  task automatic test_en_illegal;
    logic [13:0] e [10];
    e = '{14'h0, 14'h0, 14'h0, 14'h038, 14'h038, 14'h038, 14'h0, 14'h0, 14'h0, 14'h007};
    wait_fs;
    repeat (2 * RD + 10) tick;
    checks++;
    if (dot_row !== 10'b100) begin
      errors++;
      $display("FAIL en_pre: row=%b, want %b", dot_row, 10'b100);
    end
    en = 0;
    board = 18'h00300;
    is_right = 0;
    turn_o = 0;
    tick;
    checks++;
    if (dot_row !== 10'h0 || dot_col !== 14'h0) begin
      errors++;
      $display("FAIL en_off: row=%b col=%h, want 0", dot_row, dot_col);
    end
    repeat (5) tick;
    checks++;
    if (dot_row !== 10'h0 || dot_col !== 14'h0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL en_hold: row=%b col=%h fs=%b, want 0", dot_row, dot_col, frame_start);
    end
    en = 1;
    tick;
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL en_resume_fs: fs=%b, want 1", frame_start);
    end
    cap_frame(-1, '0, 1'b0);
    for (int r = 0; r < 10; r++) begin
      checks++;
      if (cr[r] !== (10'b1 << r) || cc[r] !== e[r]) begin
        errors++;
        $display("FAIL illegal row %0d: row=%b col=%h, want row=%b col=%h", r, cr[r], cc[r], 10'b1 << r, e[r]);
      end
    end
  endtask

  task automatic test_rst_mid;
    wait_fs;
    repeat (5 * RD + 10) tick;
    checks++;
    if (dot_row !== 10'b100000) begin
      errors++;
      $display("FAIL rst_mid_pre: row=%b, want %b", dot_row, 10'b100000);
    end
    rst = 1;
    tick;
    checks++;
    if (dot_row !== 10'h0 || dot_col !== 14'h0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: row=%b col=%h fs=%b, want 0", dot_row, dot_col, frame_start);
    end
    rst = 0;
    tick;
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_fs: fs=%b, want 1", frame_start);
    end
    cap_frame(-1, '0, 1'b0);
    checks++;
    if (cr[0] !== 10'b1 || cc[0] !== 14'h0 || cc[3] !== 14'h038) begin
      errors++;
      $display("FAIL rst_mid_frame: row0=%b col0=%h col3=%h, want 1/0/038", cr[0], cc[0], cc[3]);
    end
  endtask

  task automatic test_blink;
    logic [5:0] on_pat;
    logic on;
    logic [13:0] e [10];
    on_pat = 6'b011001;
    rst = 1;
    board = 18'h15200;
    win_mask = 9'h007;
    is_right = 0;
    turn_o = 0;
    tick;
    tick;
    rst = 0;
    for (int f = 0; f < 6; f++) begin
      wait_fs;
      cap_frame(-1, '0, 1'b0);
      on = on_pat[f];
      e = '{on ? 14'h16d : 14'h0, on ? 14'h092 : 14'h0, on ? 14'h16d : 14'h0,
            14'h038, 14'h028, 14'h038, 14'h0, 14'h0, 14'h0, 14'h007};
      for (int r = 0; r < 10; r++) begin
        checks++;
        if (cc[r] !== e[r]) begin
          errors++;
          $display("FAIL blink frame %0d row %0d: col=%h, want %h", f + 1, r, cc[r], e[r]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_period;
    test_x_cell1;
    test_o_cell9;
    test_tear_free;
    test_en_illegal;
    test_rst_mid;
    test_blink;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
